// File: rtl/fnd_pkg.sv
// Shared constants and types for the 4-digit FND scan controller.
package fnd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned COMM_W  = 4;
  localparam int unsigned FONT_W  = 8;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic {
    PAGE_SEC  = 1'b0,
    PAGE_HOUR = 1'b1
  } page_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] hour_10;
    logic [DIGIT_W-1:0] hour_1;
    logic [DIGIT_W-1:0] min_10;
    logic [DIGIT_W-1:0] min_1;
    logic [DIGIT_W-1:0] sec_10;
    logic [DIGIT_W-1:0] sec_1;
    logic [DIGIT_W-1:0] msec_10;
    logic [DIGIT_W-1:0] msec_1;
  } digits_t;

  localparam logic [FONT_W-1:0] FONT_DASH  = 8'hBF;
  localparam logic [FONT_W-1:0] FONT_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a} with dp off; codes 10..15 show a dash.
  localparam logic [15:0][FONT_W-1:0] FONT_TABLE = {
    FONT_DASH, FONT_DASH, FONT_DASH, FONT_DASH, FONT_DASH, FONT_DASH,
    8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  localparam logic [COMM_W-1:0] COMM_OFF = 4'b1111;
  localparam logic [3:0][COMM_W-1:0] COMM_TABLE = {
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

endpackage

// File: rtl/fnd_scan_ctrl_bcd_to_seg.sv
// BCD to active-low 7-segment decoder with a separate blank control.
module bcd_to_seg
  import fnd_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd,
  input  logic               blank,
  output logic [SEG_W-1:0]   seg_c
);

  always_comb begin
    seg_c = FONT_BLANK[SEG_W-1:0];
    if (!blank) seg_c = FONT_TABLE[bcd][SEG_W-1:0];
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Frame-snapshotted scan controller driving a 4-digit common-anode FND,
// one digit per scan tick, with a half-second decimal point indicator.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ  = 1000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_mode,
  input  logic [DIGIT_W-1:0] digit_msec_1,
  input  logic [DIGIT_W-1:0] digit_msec_10,
  input  logic [DIGIT_W-1:0] digit_sec_1,
  input  logic [DIGIT_W-1:0] digit_sec_10,
  input  logic [DIGIT_W-1:0] digit_min_1,
  input  logic [DIGIT_W-1:0] digit_min_10,
  input  logic [DIGIT_W-1:0] digit_hour_1,
  input  logic [DIGIT_W-1:0] digit_hour_10,
  output logic [COMM_W-1:0]  fnd_comm,
  output logic [FONT_W-1:0]  fnd_font
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PRE_W-1:0]   pre;
  logic [IDX_W-1:0]   idx;
  page_e              page;
  digits_t            snap;
  digits_t            digits_c;
  logic               tick_c;
  logic [DIGIT_W-1:0] digit_c;
  logic               blank_c;
  logic               dp_n_c;
  logic [SEG_W-1:0]   seg_c;

  assign digits_c = {digit_hour_10, digit_hour_1, digit_min_10, digit_min_1,
                     digit_sec_10, digit_sec_1, digit_msec_10, digit_msec_1};
  assign tick_c   = (pre == PRE_W'(DIV - 1));

  // Prescaler, scan index and per-frame capture of page and digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre  <= '0;
      idx  <= '0;
      page <= PAGE_SEC;
      snap <= '0;
    end else if (tick_c) begin
      pre <= '0;
      idx <= idx + IDX_W'(1);
      if (idx == IDX_W'(3)) begin
        page <= page_e'(sw_mode);
        snap <= digits_c;
      end
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  always_comb begin
    digit_c = snap.msec_1;
    if (page == PAGE_SEC) begin
      case (idx)
        2'd0:    digit_c = snap.msec_1;
        2'd1:    digit_c = snap.msec_10;
        2'd2:    digit_c = snap.sec_1;
        default: digit_c = snap.sec_10;
      endcase
    end else begin
      case (idx)
        2'd0:    digit_c = snap.min_1;
        2'd1:    digit_c = snap.min_10;
        2'd2:    digit_c = snap.hour_1;
        default: digit_c = snap.hour_10;
      endcase
    end
  end

  assign blank_c = (BLANK_LZ != 0) && (page == PAGE_HOUR) &&
                   (idx == IDX_W'(3)) && (snap.hour_10 == '0);
  // Decimal point lit during the first half of each second.
  assign dp_n_c  = !((idx == IDX_W'(2)) && (snap.msec_10 < DIGIT_W'(5)));

  bcd_to_seg u_bcd_to_seg (
    .bcd   (digit_c),
    .blank (blank_c),
    .seg_c (seg_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fnd_comm <= COMM_OFF;
      fnd_font <= FONT_BLANK;
    end else begin
      fnd_comm <= COMM_TABLE[idx];
      fnd_font <= {dp_n_c, seg_c};
    end
  end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl: time-based reference model plus directed literal checks.
module tb_fnd_scan_ctrl;

  localparam int unsigned CLK_HZ  = 8;
  localparam int unsigned SCAN_HZ = 2;
  localparam int unsigned DIV     = CLK_HZ / SCAN_HZ;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sw_mode = 1'b0;
  logic [3:0] msec_1 = '0, msec_10 = '0, sec_1 = '0, sec_10 = '0;
  logic [3:0] min_1 = '0, min_10 = '0, hour_1 = '0, hour_10 = '0;
  logic [3:0] fnd_comm;
  logic [7:0] fnd_font;

  int checks = 0;
  int failures = 0;

  fnd_scan_ctrl #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .BLANK_LZ(1)) dut (
    .clk           (clk),
    .reset         (reset),
    .sw_mode       (sw_mode),
    .digit_msec_1  (msec_1),
    .digit_msec_10 (msec_10),
    .digit_sec_1   (sec_1),
    .digit_sec_10  (sec_10),
    .digit_min_1   (min_1),
    .digit_min_10  (min_10),
    .digit_hour_1  (hour_1),
    .digit_hour_10 (hour_10),
    .fnd_comm      (fnd_comm),
    .fnd_font      (fnd_font)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] font_of(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  // Model: t counts clock edges since reset release. The shown digit is
  // ((t-1)/DIV)%4 and the frame is latched on every edge where t%(4*DIV)==0.
  // Snapshot order: msec_1, msec_10, sec_1, sec_10, min_1, min_10, hour_1, hour_10.
  int         t = 0;
  logic [3:0] snap_v [8];
  int         m_page = 0;
  logic       m_valid = 1'b0;
  logic [3:0] exp_comm = 4'hF;
  logic [7:0] exp_font = 8'hFF;

  always @(posedge clk) begin
    int k;
    m_valid = 1'b1;
    if (reset) begin
      t = 0;
      m_page = 0;
      for (int i = 0; i < 8; i++) snap_v[i] = '0;
      exp_comm = 4'hF;
      exp_font = 8'hFF;
    end else begin
      t = t + 1;
      k = ((t - 1) / DIV) % 4;
      exp_comm = ~(4'b0001 << k);
      if (m_page == 1 && k == 3 && snap_v[7] == 4'd0)
        exp_font = 8'hFF;
      else
        exp_font = font_of(snap_v[m_page * 4 + k]);
      if (k == 2 && snap_v[1] < 4'd5) exp_font[7] = 1'b0;
      if (t % (4 * DIV) == 0) begin
        snap_v[0] = msec_1;  snap_v[1] = msec_10;
        snap_v[2] = sec_1;   snap_v[3] = sec_10;
        snap_v[4] = min_1;   snap_v[5] = min_10;
        snap_v[6] = hour_1;  snap_v[7] = hour_10;
        m_page = int'(sw_mode);
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (fnd_comm !== exp_comm || fnd_font !== exp_font) begin
        failures++;
        $display("FAIL model t=%0d got comm=%b font=%h want comm=%b font=%h",
                 t, fnd_comm, fnd_font, exp_comm, exp_font);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_lit(input string name, input logic [3:0] comm, input logic [7:0] font);
    checks++;
    if (fnd_comm !== comm || fnd_font !== font) begin
      failures++;
      $display("FAIL %s got comm=%b font=%h want comm=%b font=%h",
               name, fnd_comm, fnd_font, comm, font);
    end
    checks++;
    if (exp_comm !== comm || exp_font !== font) begin
      failures++;
      $display("FAIL model_pin_%s got comm=%b font=%h want comm=%b font=%h",
               name, exp_comm, exp_font, comm, font);
    end
  endtask

  initial begin
    step(3);
    check_lit("in_reset", 4'b1111, 8'hFF);
    reset = 1'b0;
    step(1);  check_lit("first_after_reset", 4'b1110, 8'hC0);
    step(4);  check_lit("zero_idx1", 4'b1101, 8'hC0);
    step(4);  check_lit("zero_idx2_dp", 4'b1011, 8'h40);
    step(4);  check_lit("zero_idx3", 4'b0111, 8'hC0);
    sec_10 = 4'd4; sec_1 = 4'd2; msec_10 = 4'd7; msec_1 = 4'd3;
    step(4);  check_lit("p0_idx0", 4'b1110, 8'hB0);
    step(4);  check_lit("p0_idx1", 4'b1101, 8'hF8);
    step(4);  check_lit("p0_idx2_dp_off", 4'b1011, 8'hA4);
    step(4);  check_lit("p0_idx3", 4'b0111, 8'h99);
    msec_10 = 4'd2;
    step(12); check_lit("p0_idx2_dp_on", 4'b1011, 8'h24);
    hour_10 = 4'd0; hour_1 = 4'd9; min_10 = 4'd5; min_1 = 4'd1; sw_mode = 1'b1;
    step(8);  check_lit("p1_idx0", 4'b1110, 8'hF9);
    step(4);  check_lit("p1_idx1", 4'b1101, 8'h92);
    step(4);  check_lit("p1_idx2_dp", 4'b1011, 8'h10);
    step(4);  check_lit("p1_lz_blank", 4'b0111, 8'hFF);
    step(8);  check_lit("iso_idx1", 4'b1101, 8'h92);
    sw_mode = 1'b0; sec_1 = 4'd7;
    step(4);  check_lit("iso_idx2_old", 4'b1011, 8'h10);
    step(7);  check_lit("iso_last_old", 4'b0111, 8'hFF);
    step(1);  check_lit("iso_new_page", 4'b1110, 8'hB0);
    step(8);  check_lit("iso_new_sec1", 4'b1011, 8'h78);
    msec_1 = 4'hC;
    step(8);  check_lit("invalid_bcd", 4'b1110, 8'hBF);
    step(8);  check_lit("pre_reset", 4'b1011, 8'h78);
    reset = 1'b1;
    step(1);  check_lit("mid_reset", 4'b1111, 8'hFF);
    reset = 1'b0;
    step(1);  check_lit("restart_idx0", 4'b1110, 8'hC0);
    step(8);  check_lit("restart_idx2", 4'b1011, 8'h40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
